// File: rtl/slc3_mem_pkg.sv
// Shared definitions for the SLC-3 memory responder.
//   state_e             : responder FSM states
//   DEF_WAIT_STATES     : default wait cycles between capture and ready
//   DEF_ADDR_W          : default storage address width (2**ADDR_W words)
//   DATA_W, CNT_W       : data word width and wait-counter width
package slc3_mem_pkg;

  localparam int DEF_WAIT_STATES = 2;
  localparam int DEF_ADDR_W      = 8;
  localparam int DATA_W          = 16;
  localparam int CNT_W           = 4;   // holds WAIT_STATES up to 15

  typedef enum logic [2:0] {
    IDLE,
    READ_WAIT,
    WRITE_WAIT,
    DONE,
    RELEASE
  } state_e;

endpackage

// File: rtl/slc3_mem_array.sv
// Single-port word storage for the SLC-3 memory responder.
//   clk    : rising-edge clock
//   reset  : synchronous active-high, clears only the read-data register
//   we     : write strobe, stores wdata at addr
//   re     : read strobe, loads rdata from addr
//   addr   : shared read/write address
//   wdata  : write data
//   rdata  : registered read data, held between reads
module slc3_mem_array
  import slc3_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  // NOTE: the storage array has no reset; clearing it would force a flop
  // implementation and would also wipe a preloaded program on every reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // NOTE: sequential state is always assigned with <= so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/slc3_mem_responder.sv
// SRAM-style responder for an SLC-3 CPU: captures a read or write request,
// waits WAIT_STATES cycles, performs the access and pulses R for one cycle,
// then waits for the request to be released. Also accepts preload writes.
//   Clk, Reset      : clock and synchronous active-high reset
//   ADDR            : word address (upper bits beyond ADDR_W ignored)
//   Data_to_SRAM    : CPU write data
//   OE, WE          : active-low read / write requests (write wins)
//   Data_from_SRAM  : last read result, held until the next read completes
//   R               : one-cycle ready pulse on access completion
//   Init_En/Addr/Data : preload write, honoured only when idle and no request
//   Busy            : high whenever the FSM is not in IDLE
module slc3_mem_responder
  import slc3_mem_pkg::*;
#(
  parameter int WAIT_STATES = DEF_WAIT_STATES,
  parameter int ADDR_W      = DEF_ADDR_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [15:0]       ADDR,
  input  logic [DATA_W-1:0] Data_to_SRAM,
  input  logic              OE,
  input  logic              WE,
  output logic [DATA_W-1:0] Data_from_SRAM,
  output logic              R,
  input  logic              Init_En,
  input  logic [15:0]       Init_Addr,
  input  logic [DATA_W-1:0] Init_Data,
  output logic              Busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              mem_we, mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  // Upper address bits are intentionally dropped so addresses wrap.
  if (ADDR_W < 16) begin : g_unused_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^{ADDR[15:ADDR_W], Init_Addr[15:ADDR_W]};
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case statement can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = data_q;

    unique case (state_q)
      IDLE: begin
        if (!WE) begin
          addr_d  = ADDR[ADDR_W-1:0];
          data_d  = Data_to_SRAM;
          cnt_d   = CNT_LOAD;
          state_d = WRITE_WAIT;
        end else if (!OE) begin
          addr_d  = ADDR[ADDR_W-1:0];
          cnt_d   = CNT_LOAD;
          state_d = READ_WAIT;
        end else if (Init_En) begin
          mem_we    = 1'b1;
          mem_addr  = Init_Addr[ADDR_W-1:0];
          mem_wdata = Init_Data;
        end
      end
      WRITE_WAIT: begin
        if (WE) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          mem_we  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      READ_WAIT: begin
        if (OE) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          mem_re  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      DONE: begin
        state_d = RELEASE;
      end
      RELEASE: begin
        if (OE && WE) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset must also block a write that would commit on the same edge.
  slc3_mem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (Clk),
    .reset (Reset),
    .we    (mem_we && !Reset),
    .re    (mem_re && !Reset),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (Data_from_SRAM)
  );

  assign R    = (state_q == DONE);
  assign Busy = (state_q != IDLE);

endmodule

// File: tb/tb_slc3_mem_responder.sv
// Directed self-checking bench for slc3_mem_responder (WAIT_STATES=2, ADDR_W=8).
module tb_slc3_mem_responder;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] ADDR;
  logic [15:0] Data_to_SRAM;
  logic        OE;
  logic        WE;
  logic [15:0] Data_from_SRAM;
  logic        R;
  logic        Init_En;
  logic [15:0] Init_Addr;
  logic [15:0] Init_Data;
  logic        Busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  slc3_mem_responder #(.WAIT_STATES(2), .ADDR_W(8)) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .ADDR           (ADDR),
    .Data_to_SRAM   (Data_to_SRAM),
    .OE             (OE),
    .WE             (WE),
    .Data_from_SRAM (Data_from_SRAM),
    .R              (R),
    .Init_En        (Init_En),
    .Init_Addr      (Init_Addr),
    .Init_Data      (Init_Data),
    .Busy           (Busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Counts edges until R is seen; -1 if it never arrives within the budget.
  task automatic wait_r(output int lat);
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (R) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [15:0] d, output int lat);
    ADDR = a;
    OE   = 1'b0;
    tick();
    wait_r(lat);
    d  = Data_from_SRAM;
    OE = 1'b1;
    tick();
    tick();
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [15:0] dat, output int lat);
    ADDR         = a;
    Data_to_SRAM = dat;
    WE           = 1'b0;
    tick();
    wait_r(lat);
    WE = 1'b1;
    tick();
    tick();
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    Init_Addr = a;
    Init_Data = d;
    Init_En   = 1'b1;
    tick();
    Init_En   = 1'b0;
  endtask

  initial begin
    logic [15:0] rd;
    int          lat;
    int          pulses;

    Reset = 1'b1; OE = 1'b1; WE = 1'b1; Init_En = 1'b0;
    ADDR = '0; Data_to_SRAM = '0; Init_Addr = '0; Init_Data = '0;
    tick();
    tick();
    Reset = 1'b0;
    check("reset_r",    32'(R),              32'h0);
    check("reset_busy", 32'(Busy),           32'h0);
    check("reset_data", 32'(Data_from_SRAM), 32'h0);

    // Preload then basic read latency.
    preload(16'h0005, 16'h1234);
    check("init_busy", 32'(Busy), 32'h0);
    cpu_read(16'h0005, rd, lat);
    check("read_lat",  32'(lat), 32'd3);
    check("read_data", 32'(rd),  32'h1234);
    check("read_release_busy", 32'(Busy), 32'h0);

    // Write with high address bits set, read back through the wrapped address.
    cpu_write(16'h0105, 16'hBEEF, lat);
    check("write_lat",  32'(lat), 32'd3);
    check("write_holds_rdata", 32'(Data_from_SRAM), 32'h1234);
    cpu_read(16'h0005, rd, lat);
    check("wrap_lat",  32'(lat), 32'd3);
    check("wrap_data", 32'(rd),  32'hBEEF);

    // OE and WE together: write wins, a single R, read data untouched.
    ADDR = 16'h0010; Data_to_SRAM = 16'h00AA; OE = 1'b0; WE = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (R) pulses++;
    end
    OE = 1'b1; WE = 1'b1;
    tick();
    tick();
    check("both_pulses", 32'(pulses), 32'd1);
    check("both_busy",   32'(Busy),   32'h0);
    check("both_no_read", 32'(Data_from_SRAM), 32'hBEEF);
    cpu_read(16'h0010, rd, lat);
    check("both_data", 32'(rd), 32'h00AA);

    // Held read gives exactly one R; Init_En while busy is ignored.
    preload(16'h0040, 16'h0101);
    ADDR = 16'h0005; OE = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin
        Init_Addr = 16'h0040; Init_Data = 16'h7777; Init_En = 1'b1;
      end
      if (i == 6) Init_En = 1'b0;
      tick();
      if (R) pulses++;
    end
    check("hold_pulses", 32'(pulses), 32'd1);
    check("hold_busy",   32'(Busy),   32'h1);
    check("hold_data",   32'(Data_from_SRAM), 32'hBEEF);
    OE = 1'b1;
    tick();
    check("hold_release_busy", 32'(Busy), 32'h0);
    cpu_read(16'h0040, rd, lat);
    check("init_ignored_busy", 32'(rd), 32'h0101);

    // Write aborted after one cycle: no R, word unchanged.
    preload(16'h0020, 16'h5555);
    ADDR = 16'h0020; Data_to_SRAM = 16'hDEAD; WE = 1'b0;
    tick();
    WE = 1'b1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (R) pulses++;
    end
    check("abort_pulses", 32'(pulses), 32'd0);
    check("abort_busy",   32'(Busy),   32'h0);
    cpu_read(16'h0020, rd, lat);
    check("abort_data", 32'(rd), 32'h5555);

    // Reset on the edge that would commit the write.
    preload(16'h0030, 16'h1111);
    ADDR = 16'h0030; Data_to_SRAM = 16'h2222; WE = 1'b0;
    tick();
    tick();
    tick();
    Reset = 1'b1;
    tick();
    check("rst_ww_r",    32'(R),              32'h0);
    check("rst_ww_busy", 32'(Busy),           32'h0);
    check("rst_ww_data", 32'(Data_from_SRAM), 32'h0);
    Reset = 1'b0; WE = 1'b1;
    tick();
    cpu_read(16'h0030, rd, lat);
    check("rst_ww_word", 32'(rd), 32'h1111);

    // Request held through reset is served afresh after release.
    ADDR = 16'h0030; OE = 1'b0;
    tick();
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    wait_r(lat);
    check("rst_rerun_lat",  32'(lat), 32'd4);
    check("rst_rerun_data", 32'(Data_from_SRAM), 32'h1111);
    OE = 1'b1;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
